// File: rtl/bsg_axil_dma_pkg.sv
// Shared definitions for the AXI-lite DMA sequencer.
// Holds the sequencer state encoding and the DMA configuration register
// offsets, relative to the DMA base address.
package bsg_axil_dma_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_SRC,
    WR_DST,
    WR_LEN,
    WR_STRIDE,
    WR_START,
    WAIT_DONE,
    WR_CLR,
    REPORT
  } state_e;

  localparam logic [7:0] src_offset    = 8'h00;
  localparam logic [7:0] dst_offset    = 8'h04;
  localparam logic [7:0] len_offset    = 8'h08;
  localparam logic [7:0] stride_offset = 8'h0C;
  localparam logic [7:0] start_offset  = 8'h10;
  localparam logic [7:0] clr_offset    = 8'h14;

endpackage

// File: rtl/bsg_axil_dma_sequencer_if.sv
// AXI-lite write-only bundle (aw, w and b channels).
// master: drives awaddr/awprot/awvalid, wdata/wstrb/wvalid, bready.
// slave : drives awready, wready, bresp, bvalid.
interface bsg_axil_dma_sequencer_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic [addr_width_p-1:0]   awaddr;
  logic [2:0]                awprot;
  logic                      awvalid;
  logic                      awready;
  logic [data_width_p-1:0]   wdata;
  logic [data_width_p/8-1:0] wstrb;
  logic                      wvalid;
  logic                      wready;
  logic [1:0]                bresp;
  logic                      bvalid;
  logic                      bready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/bsg_axil_single_write.sv
// One AXI-lite write: while v is high, awvalid and wvalid are raised and each
// drops after its own handshake (either order, or both together). bready is
// raised only once both handshakes are done; done pulses on the b handshake
// and err flags a nonzero bresp on that same cycle.
// Ports: clk, rst, v, addr, data, done, err, axil (master modport).
module bsg_axil_single_write #(
  parameter int axil_addr_width_p = 32,
  parameter int axil_data_width_p = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         v,
  input  logic [axil_addr_width_p-1:0] addr,
  input  logic [axil_data_width_p-1:0] data,
  output logic                         done,
  output logic                         err,
  bsg_axil_dma_sequencer_if.master     axil
);

  logic aw_done_r;
  logic w_done_r;

  // Handshake progress; cleared when the write completes so that a
  // following write starting next cycle re-raises both valids.
  always_ff @(posedge clk) begin
    if (rst || !v || done) begin
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
    end else begin
      if (axil.awvalid && axil.awready) aw_done_r <= 1'b1;
      if (axil.wvalid && axil.wready)   w_done_r  <= 1'b1;
    end
  end

  assign axil.awaddr  = addr;
  assign axil.awprot  = 3'b000;
  assign axil.awvalid = v && !aw_done_r;
  assign axil.wdata   = data;
  assign axil.wstrb   = '1;
  assign axil.wvalid  = v && !w_done_r;
  assign axil.bready  = v && aw_done_r && w_done_r;

  assign done = axil.bvalid && axil.bready;
  assign err  = done && (axil.bresp != 2'b00);

endmodule

// File: rtl/bsg_axil_dma_sequencer.sv
// Programs a DMA engine over AXI-lite from one descriptor at a time:
// writes src, dst, length, stride and start, waits for the DMA interrupt,
// clears it, then reports completion (with a sticky bresp error) until
// consumed.
// Ports: clk_i/reset_i; desc_* descriptor input (valid/ready);
// done_v_o/done_err_o/done_yumi_i completion; m_axil AXI-lite master;
// dma_interrupt_i level interrupt; busy_o; count_o completed descriptors.
module bsg_axil_dma_sequencer
  import bsg_axil_dma_pkg::*;
#(
  parameter int                           axil_addr_width_p = 32,
  parameter int                           axil_data_width_p = 32,
  parameter int                           lg_max_length_p   = 16,
  parameter int                           lg_max_stride_p   = 8,
  parameter logic [axil_addr_width_p-1:0] dma_base_addr_p   = '0
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       desc_v_i,
  input  logic [31:0]                desc_src_i,
  input  logic [31:0]                desc_dst_i,
  input  logic [lg_max_length_p-1:0] desc_len_i,
  input  logic [lg_max_stride_p-1:0] desc_stride_i,
  output logic                       desc_ready_o,
  output logic                       done_v_o,
  output logic                       done_err_o,
  input  logic                       done_yumi_i,
  bsg_axil_dma_sequencer_if.master   m_axil,
  input  logic                       dma_interrupt_i,
  output logic                       busy_o,
  output logic [15:0]                count_o
);

  state_e state_r, state_n;
  logic   err_r;
  logic [15:0] count_r;

  logic [31:0]                src_r;
  logic [31:0]                dst_r;
  logic [lg_max_length_p-1:0] len_r;
  logic [lg_max_stride_p-1:0] stride_r;

  logic                         wr_v;
  logic [7:0]                   wr_off;
  logic [axil_data_width_p-1:0] wr_data;
  logic                         wr_done;
  logic                         wr_err;

  bsg_axil_single_write #(
    .axil_addr_width_p(axil_addr_width_p),
    .axil_data_width_p(axil_data_width_p)
  ) writer (
    .clk (clk_i),
    .rst (reset_i),
    .v   (wr_v),
    .addr(dma_base_addr_p + axil_addr_width_p'(wr_off)),
    .data(wr_data),
    .done(wr_done),
    .err (wr_err),
    .axil(m_axil)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      err_r   <= 1'b0;
      count_r <= '0;
    end else begin
      state_r <= state_n;
      if (state_r == REPORT && done_yumi_i) begin
        err_r   <= 1'b0;
        count_r <= count_r + 16'd1;
      end else if (wr_err) begin
        err_r <= 1'b1;
      end
    end
  end

  // Descriptor fields are pure data: captured on acceptance, never reset.
  always_ff @(posedge clk_i) begin
    if (state_r == IDLE && desc_v_i) begin
      src_r    <= desc_src_i;
      dst_r    <= desc_dst_i;
      len_r    <= desc_len_i;
      stride_r <= desc_stride_i;
    end
  end

  always_comb begin
    state_n      = state_r;
    wr_v         = 1'b0;
    wr_off       = '0;
    wr_data      = '0;
    desc_ready_o = 1'b0;
    done_v_o     = 1'b0;
    done_err_o   = 1'b0;
    case (state_r)
      IDLE: begin
        desc_ready_o = 1'b1;
        if (desc_v_i) state_n = WR_SRC;
      end
      WR_SRC: begin
        wr_v    = 1'b1;
        wr_off  = src_offset;
        wr_data = axil_data_width_p'(src_r);
        if (wr_done) state_n = WR_DST;
      end
      WR_DST: begin
        wr_v    = 1'b1;
        wr_off  = dst_offset;
        wr_data = axil_data_width_p'(dst_r);
        if (wr_done) state_n = WR_LEN;
      end
      WR_LEN: begin
        wr_v    = 1'b1;
        wr_off  = len_offset;
        wr_data = axil_data_width_p'(len_r);
        if (wr_done) state_n = WR_STRIDE;
      end
      WR_STRIDE: begin
        wr_v    = 1'b1;
        wr_off  = stride_offset;
        wr_data = axil_data_width_p'(stride_r);
        if (wr_done) state_n = WR_START;
      end
      WR_START: begin
        wr_v    = 1'b1;
        wr_off  = start_offset;
        wr_data = axil_data_width_p'(1);
        if (wr_done) state_n = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (dma_interrupt_i) state_n = WR_CLR;
      end
      WR_CLR: begin
        wr_v    = 1'b1;
        wr_off  = clr_offset;
        wr_data = axil_data_width_p'(1);
        if (wr_done) state_n = REPORT;
      end
      REPORT: begin
        done_v_o   = 1'b1;
        done_err_o = err_r;
        if (done_yumi_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy_o  = (state_r != IDLE);
  assign count_o = count_r;

endmodule

// File: tb/tb_bsg_axil_dma_sequencer.sv
module tb_bsg_axil_dma_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        desc_v = 1'b0;
  logic [31:0] desc_src = '0;
  logic [31:0] desc_dst = '0;
  logic [15:0] desc_len = '0;
  logic [7:0]  desc_stride = '0;
  logic        desc_ready;
  logic        done_v;
  logic        done_err;
  logic        done_yumi = 1'b0;
  logic        dma_int = 1'b0;
  logic        busy;
  logic [15:0] count;

  always #5 clk = ~clk;

  bsg_axil_dma_sequencer_if #(.addr_width_p(32), .data_width_p(32)) axil ();

  bsg_axil_dma_sequencer dut (
    .clk_i          (clk),
    .reset_i        (rst),
    .desc_v_i       (desc_v),
    .desc_src_i     (desc_src),
    .desc_dst_i     (desc_dst),
    .desc_len_i     (desc_len),
    .desc_stride_i  (desc_stride),
    .desc_ready_o   (desc_ready),
    .done_v_o       (done_v),
    .done_err_o     (done_err),
    .done_yumi_i    (done_yumi),
    .m_axil         (axil),
    .dma_interrupt_i(dma_int),
    .busy_o         (busy),
    .count_o        (count)
  );

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  int aw_delay = 0;
  int w_delay  = 0;
  int aw_cnt   = 0;
  int w_cnt    = 0;
  int b_cnt    = 0;
  int early    = 0;
  logic        err_en   = 1'b0;
  logic [31:0] err_addr = '0;
  logic        aw_seen  = 1'b0;
  logic        w_seen   = 1'b0;
  logic [31:0] aw_q[$];
  logic [31:0] w_q[$];

  // Slave responder and handshake monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    aw_cnt = axil.awvalid ? aw_cnt + 1 : 0;
    w_cnt  = axil.wvalid  ? w_cnt + 1  : 0;
    axil.awready = (aw_cnt > aw_delay);
    axil.wready  = (w_cnt > w_delay);
    axil.bvalid  = 1'b1;
    axil.bresp   = (err_en && axil.awaddr == err_addr) ? 2'b10 : 2'b00;
    if (rst) begin
      aw_seen = 1'b0;
      w_seen  = 1'b0;
    end else begin
      if (axil.bready && !(aw_seen && w_seen)) early++;
      if (axil.awvalid && axil.awready) begin
        aw_q.push_back(axil.awaddr);
        aw_seen = 1'b1;
      end
      if (axil.wvalid && axil.wready) begin
        w_q.push_back(axil.wdata);
        w_seen = 1'b1;
      end
      if (axil.bvalid && axil.bready) begin
        b_cnt++;
        aw_seen = 1'b0;
        w_seen  = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    aw_q.delete();
    w_q.delete();
    b_cnt = 0;
    early = 0;
  endtask

  task automatic send(input logic [31:0] src, input logic [31:0] dst,
                      input logic [15:0] len, input logic [7:0] stride);
    desc_src = src; desc_dst = dst; desc_len = len; desc_stride = stride;
    desc_v = 1'b1;
    for (int i = 0; i < 50 && !desc_ready; i++) tick();
    chk("desc_ready", desc_ready, 1);
    tick();
    desc_v = 1'b0;
  endtask

  task automatic wait_b(input int n);
    for (int i = 0; i < 300 && b_cnt < n; i++) tick();
    chk("b_count", b_cnt, n);
  endtask

  task automatic finish_desc(output logic err);
    dma_int = 1'b1;
    tick();
    dma_int = 1'b0;
    for (int i = 0; i < 100 && !done_v; i++) tick();
    chk("done_v", done_v, 1);
    err = done_err;
    done_yumi = 1'b1;
    tick();
    done_yumi = 1'b0;
  endtask

  task automatic check_seq(input string tag, input logic [31:0] src,
                           input logic [31:0] dst, input logic [31:0] len,
                           input logic [31:0] stride);
    logic [31:0] exp_a[6];
    logic [31:0] exp_d[6];
    exp_a = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14};
    exp_d = '{src, dst, len, stride, 32'd1, 32'd1};
    chk({tag, "_aw_n"}, aw_q.size(), 6);
    chk({tag, "_w_n"}, w_q.size(), 6);
    chk({tag, "_b_n"}, b_cnt, 6);
    chk({tag, "_early"}, early, 0);
    for (int i = 0; i < 6 && i < aw_q.size() && i < w_q.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), aw_q[i], exp_a[i]);
      chk($sformatf("%s_data%0d", tag, i), w_q[i], exp_d[i]);
    end
  endtask

  initial begin
    logic err;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_done_v", done_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", count, 0);
    chk("rst_bready", axil.bready, 0);
    chk("rst_awvalid", axil.awvalid, 0);
    chk("awprot", axil.awprot, 0);
    chk("wstrb", axil.wstrb, 4'hF);

    // Basic descriptor, all ready
    clear_log();
    send(32'h1000, 32'h2000, 16'd16, 8'd4);
    chk("busy_running", busy, 1);
    chk("ready_running", desc_ready, 0);
    wait_b(5);
    for (int i = 0; i < 5; i++) tick();
    chk("wait_no_writes", b_cnt, 5);
    chk("wait_no_done", done_v, 0);
    chk("wait_busy", busy, 1);
    finish_desc(err);
    chk("basic_err", err, 0);
    chk("basic_count", count, 1);
    chk("basic_idle", busy, 0);
    check_seq("basic", 32'h1000, 32'h2000, 32'd16, 32'd4);

    // wready lags awready by 3 cycles
    clear_log();
    aw_delay = 0; w_delay = 3;
    send(32'hA0, 32'hB0, 16'd0, 8'd0);
    wait_b(5);
    finish_desc(err);
    check_seq("wlag", 32'hA0, 32'hB0, 32'd0, 32'd0);

    // awready lags wready by 3 cycles
    clear_log();
    aw_delay = 3; w_delay = 0;
    send(32'hC0, 32'hD0, 16'd7, 8'd255);
    wait_b(5);
    finish_desc(err);
    check_seq("awlag", 32'hC0, 32'hD0, 32'd7, 32'd255);
    chk("lag_count", count, 3);

    // Error response on the length write
    clear_log();
    aw_delay = 0; w_delay = 0;
    err_en = 1'b1; err_addr = 32'h08;
    send(32'h11, 32'h22, 16'hFFFF, 8'h01);
    wait_b(5);
    finish_desc(err);
    chk("bresp_err", err, 1);
    check_seq("bresp", 32'h11, 32'h22, 32'hFFFF, 32'h01);
    err_en = 1'b0;
    clear_log();
    send(32'h33, 32'h44, 16'd2, 8'd2);
    wait_b(5);
    finish_desc(err);
    chk("err_cleared", err, 0);

    // Back-to-back descriptors with desc_v held high
    rst = 1'b1; tick(); rst = 1'b0;
    clear_log();
    desc_src = 32'h5000; desc_dst = 32'h6000; desc_len = 16'd8; desc_stride = 8'd1;
    desc_v = 1'b1;
    tick();
    desc_src = 32'h7000; desc_dst = 32'h8000; desc_len = 16'd9; desc_stride = 8'd3;
    wait_b(5);
    dma_int = 1'b1; tick(); dma_int = 1'b0;
    for (int i = 0; i < 100 && !done_v; i++) tick();
    tick(); tick();
    chk("b2b_report_hold", done_v, 1);
    chk("b2b_not_ready", desc_ready, 0);
    chk("b2b_count0", count, 0);
    done_yumi = 1'b1;
    tick();
    chk("b2b_count1", count, 1);
    chk("b2b_idle_ready", desc_ready, 1);
    clear_log();
    tick();
    chk("b2b_second_busy", busy, 1);
    chk("b2b_second_ready", desc_ready, 0);
    tick(); tick(); tick();
    done_yumi = 1'b0;
    desc_v = 1'b0;
    wait_b(5);
    finish_desc(err);
    chk("b2b_count2", count, 2);
    check_seq("b2b", 32'h7000, 32'h8000, 32'd9, 32'd3);

    // Reset during WAIT_DONE
    clear_log();
    send(32'h1, 32'h2, 16'd3, 8'd4);
    wait_b(5);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rstw_busy", busy, 0);
    chk("rstw_done_v", done_v, 0);
    chk("rstw_count", count, 0);
    chk("rstw_ready", desc_ready, 1);

    // Reset with awvalid outstanding
    aw_delay = 10; w_delay = 10;
    send(32'h3, 32'h4, 16'd5, 8'd6);
    chk("pend_awvalid", axil.awvalid, 1);
    chk("pend_wvalid", axil.wvalid, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rsta_awvalid", axil.awvalid, 0);
    chk("rsta_wvalid", axil.wvalid, 0);
    chk("rsta_bready", axil.bready, 0);
    chk("rsta_busy", busy, 0);
    chk("rsta_done_v", done_v, 0);

    // Normal run after the reset
    aw_delay = 0; w_delay = 0;
    tick();
    clear_log();
    send(32'h9000, 32'hA000, 16'd1, 8'd1);
    wait_b(5);
    finish_desc(err);
    chk("post_err", err, 0);
    chk("post_count", count, 1);
    check_seq("post", 32'h9000, 32'hA000, 32'd1, 32'd1);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/bsg_axil_dma_sequencer.md
BSG_AXIL_DMA_SEQUENCER -- requirements
Module: bsg_axil_dma_sequencer

Interface
REQ-001 The block SHALL have parameter axil_addr_width_p, default 32: AXI-lite address width.
REQ-002 The block SHALL have parameter axil_data_width_p, default 32: AXI-lite data width (fixed at 32).
REQ-003 The block SHALL have parameter lg_max_length_p, default 16: descriptor length field width.
REQ-004 The block SHALL have parameter lg_max_stride_p, default 8: descriptor stride field width.
REQ-005 The block SHALL have parameter dma_base_addr_p, default 0: base address of the DMA configuration registers.
REQ-006 The block SHALL run on one clock; reset is synchronous and active-high. Ports are listed below (name, direction, width, meaning).
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- desc_v_i  in  1  descriptor valid.
- desc_src_i  in  32  source address.
- desc_dst_i  in  32  destination address.
- desc_len_i  in  lg_max_length_p  transfer length in words.
- desc_stride_i  in  lg_max_stride_p  stride.
- desc_ready_o  out  1  descriptor accepted when valid and ready are both high.
- done_v_o  out  1  completion valid.
- done_err_o  out  1  a bresp was nonzero during this descriptor.
- done_yumi_i  in  1  completion consumed.
- m_axil_awaddr_o, awprot_o (3), awvalid_o, awready_i: AXI-lite write address channel to the DMA configuration port.
- m_axil_wdata_o, wstrb_o, wvalid_o, wready_i: AXI-lite write data channel.
- m_axil_bresp_i (2), bvalid_i, bready_o: AXI-lite write response channel.
- dma_interrupt_i  in  1  DMA done interrupt (level).
- busy_o  out  1  high when not in IDLE.
- count_o  out  16  number of completed descriptors.

Function
REQ-007 The block SHALL use states IDLE, WR_SRC, WR_DST, WR_LEN, WR_STRIDE, WR_START, WAIT_DONE, WR_CLR, REPORT.
REQ-008 In IDLE, desc_ready_o SHALL be 1; on desc_v_i the descriptor SHALL be latched and the state SHALL go to WR_SRC.
REQ-009 desc_ready_o SHALL be 0 in every state except IDLE.
REQ-010 The write states SHALL target these offsets from dma_base_addr_p:
- WR_SRC 0x00, data = src.
- WR_DST 0x04, data = dst.
- WR_LEN 0x08, data = length, zero-extended.
- WR_STRIDE 0x0C, data = stride, zero-extended.
- WR_START 0x10, data = 1.
- WR_CLR 0x14, data = 1.
REQ-011 Each write SHALL raise awvalid_o and wvalid_o in the cycle the state is entered.
REQ-012 awvalid_o and wvalid_o SHALL each drop independently after their own handshake; the block SHALL tolerate either order, including both in the same cycle.
REQ-013 bready_o SHALL be 1 only after both the address and data handshakes of the current write are complete.
REQ-014 The state SHALL advance on the bvalid_i & bready_o handshake; a write SHALL take at least 2 cycles.
REQ-015 awprot_o SHALL be 0 and wstrb_o SHALL be all ones.
REQ-016 A bresp_i other than 2'b00 SHALL set a sticky error flag; the sequence SHALL continue.
REQ-017 WAIT_DONE SHALL move to WR_CLR in the cycle after dma_interrupt_i is sampled high; there SHALL be no timeout.
REQ-018 REPORT SHALL hold done_v_o = 1 and done_err_o = the error flag until done_yumi_i.
REQ-019 On done_yumi_i, count_o SHALL increment (wrapping at 2^16), the error flag SHALL clear, and the state SHALL return to IDLE.
REQ-020 A descriptor with length 0 SHALL be issued unchanged; the block SHALL not special-case it.

Reset
REQ-021 reset_i SHALL force IDLE, valid outputs 0, bready_o 0, error flag 0, count_o 0, and busy_o 0.
REQ-022 Reset in mid-operation SHALL abandon the AXI transaction immediately, with no completion produced.

Structure
REQ-023 The register offsets and the state enum SHALL live in the shared package bsg_axil_dma_pkg, which bsg_axil_dma also uses.
REQ-024 The per-write AXI-lite handshake SHALL be one sub-module, bsg_axil_single_write, with inputs v/addr/data, outputs done/err, and the aw/w/b ports.

Verification
REQ-025 Descriptor src=0x1000, dst=0x2000, len=16, stride=4, with awready, wready, and bvalid always 1 -> writes occur in order 0x00, 0x04, 0x08, 0x0C, 0x10 with data 0x1000, 0x2000, 16, 4, 1; the block then waits; interrupt -> write 0x14 = 1, then done_v_o = 1, err = 0, count_o = 1.
REQ-026 wready delayed 3 cycles after awready, and the reverse -> each write completes exactly once and bready_o is never asserted early.
REQ-027 bresp = 2'b10 on the WR_LEN write -> all remaining writes still issue, and done_err_o = 1; the next descriptor reports err = 0.
REQ-028 desc_v_i held high for two back-to-back descriptors, done_yumi_i held for 5 cycles -> the second descriptor is accepted only after yumi; count_o reaches 2.
REQ-029 reset_i pulsed during WAIT_DONE, and again with awvalid outstanding -> all outputs return to reset values the next cycle; a new descriptor then runs normally.
